player_input_checker: RTL and testbench

Checks the player's key presses against the stored 15-bit colour sequence for one round of the memory game. It sits downstream of the sequence register and consumes its 15-bit output alongside the player key path. It walks positions 1..level, compares each key colour with the expected colour, and enforces a per-key timeout. It reports a one-cycle pass or fail pulse to the game controller.

---
 rtl/player_input_checker_pkg.sv | 26 ++
 rtl/mux5to1.sv | 30 +++
 rtl/player_input_checker_timer.sv | 42 ++++
 rtl/player_input_checker.sv | 164 ++++++++++++++++
 tb/tb_player_input_checker.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_input_checker_pkg.sv
// -----------------------------------------------------------------------------
// player_input_checker_pkg
// Shared definitions for the memory-game input checker. The game controller
// imports the same package so that it decodes the checker's FSM state with
// the same 2-bit encoding used here.
//   NUM_COLOURS : colour slots held in one stored sequence
//   COLOUR_W    : bits per colour
//   INDEX_W     : width of the 1-based position counter (0 means idle)
//   LEVEL_W     : width of the round-length input
//   state_t     : checker FSM states
// -----------------------------------------------------------------------------
package player_input_checker_pkg;

    localparam int NUM_COLOURS = 5;
    localparam int COLOUR_W    = 3;
    localparam int INDEX_W     = 4;
    localparam int LEVEL_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_PASS     = 2'd2,
        ST_FAIL     = 2'd3
    } state_t;

endpackage

// File: rtl/mux5to1.sv
// -----------------------------------------------------------------------------
// mux5to1
// Selects one of five W-bit fields from a packed word using a 1-based select.
// Field 1 is data[W-1:0]. Any select outside 1..5 (including 0) yields zero,
// so an idle position counter produces a zero colour.
//   sel  : 1-based field select
//   data : five packed W-bit fields
//   y    : selected field
// -----------------------------------------------------------------------------
module mux5to1 #(
    parameter int W = 3
) (
    input  logic [3:0]     sel,
    input  logic [5*W-1:0] data,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        case (sel)
            4'd1:    y = data[W-1:0];
            4'd2:    y = data[2*W-1:W];
            4'd3:    y = data[3*W-1:2*W];
            4'd4:    y = data[4*W-1:3*W];
            4'd5:    y = data[5*W-1:4*W];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/player_input_checker_timer.sv
// -----------------------------------------------------------------------------
// key_timeout_timer
// Up-counter measuring the gap since round start or the last accepted key.
// The count saturates at TIMEOUT_CYCLES-1; the expiry flag is registered one
// cycle after the count reaches that value, so a timeout is reported
// TIMEOUT_CYCLES+1 edges after the clearing edge.
//   clock, Resetn : clock and asynchronous active-low reset
//   clear         : reload the count to zero and drop the expiry flag
//   enable        : advance the count this cycle
//   expired       : gap has reached the timeout
// -----------------------------------------------------------------------------
module key_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int TIMER_W        = 28
) (
    input  logic clock,
    input  logic Resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable) begin
            expired <= (count == LAST);
            if (count != LAST) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_input_checker.sv
// -----------------------------------------------------------------------------
// player_input_checker
// Checks one round of player key presses against a captured colour sequence,
// position 1 up to the captured level, with a per-key timeout. Reports a
// one-cycle pass or fail pulse.
//
// Handshake: start and key_valid are single-cycle pulses with no ready.
// start is only acted on in IDLE with a legal level; key_valid/key_colour are
// only acted on in WAIT_KEY. Pulses arriving in any other state are dropped.
//
// Ports
//   clock, Resetn   : clock, asynchronous active-low reset
//   start, level    : round request and its length (1..NUM_COLOURS)
//   colour_seq      : stored sequence, position i in bits [3i-1:3i-3]
//   key_valid       : key press pulse
//   key_colour      : colour of the pressed key
//   busy            : round in progress
//   index           : 1-based position expected next, 0 when idle
//   expected_colour : colour at index in the captured sequence
//   round_pass      : one-cycle pulse, all keys matched
//   round_fail      : one-cycle pulse, mismatch or timeout
//   timed_out       : last failure was a timeout, held until next start
//   debug_state     : current FSM state
// -----------------------------------------------------------------------------
module player_input_checker #(
    parameter int NUM_COLOURS    = player_input_checker_pkg::NUM_COLOURS,
    parameter int COLOUR_W       = player_input_checker_pkg::COLOUR_W,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int TIMER_W        = 28
) (
    input  logic                            clock,
    input  logic                            Resetn,
    input  logic                            start,
    input  logic [2:0]                      level,
    input  logic [NUM_COLOURS*COLOUR_W-1:0] colour_seq,
    input  logic                            key_valid,
    input  logic [COLOUR_W-1:0]             key_colour,
    output logic                            busy,
    output logic [3:0]                      index,
    output logic [COLOUR_W-1:0]             expected_colour,
    output logic                            round_pass,
    output logic                            round_fail,
    output logic                            timed_out,
    output logic [1:0]                      debug_state
);

    import player_input_checker_pkg::*;

    localparam int SEQ_W = NUM_COLOURS * COLOUR_W;
    localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_COLOURS);

    state_t               state_q, state_d;
    logic [SEQ_W-1:0]     seq_q;
    logic [LEVEL_W-1:0]   level_q;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic                 timed_out_q;

    logic                 start_ok;
    logic                 key_match;
    logic                 capture;
    logic                 set_timeout;
    logic                 timer_clear;
    logic                 timer_enable;
    logic                 timer_expired;

    assign start_ok  = start && (level != '0) && (level <= MAX_LEVEL);
    assign key_match = (key_colour == expected_colour);

    // Colour at the current position of the captured sequence.
    mux5to1 #(
        .W (COLOUR_W)
    ) u_colour_mux (
        .sel  (index_q),
        .data (seq_q),
        .y    (expected_colour)
    );

    key_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .Resetn  (Resetn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            level_q     <= '0;
            index_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (capture) begin
                seq_q   <= colour_seq;
                level_q <= level;
            end
            if (capture) begin
                timed_out_q <= 1'b0;
            end else if (set_timeout) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        capture      = 1'b0;
        set_timeout  = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                index_d = '0;
                if (start_ok) begin
                    capture     = 1'b1;
                    timer_clear = 1'b1;
                    index_d     = INDEX_W'(1);
                    state_d     = ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                timer_enable = 1'b1;
                // A key in the expiry cycle wins over the timeout.
                if (key_valid) begin
                    if (!key_match) begin
                        state_d = ST_FAIL;
                    end else if (index_q == INDEX_W'(level_q)) begin
                        state_d = ST_PASS;
                    end else begin
                        index_d     = index_q + 1'b1;
                        timer_clear = 1'b1;
                    end
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    state_d     = ST_FAIL;
                end
            end
            // index holds through the pulse cycle and clears on return to IDLE.
            ST_PASS, ST_FAIL: begin
                index_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                index_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_WAIT_KEY);
    assign round_pass  = (state_q == ST_PASS);
    assign round_fail  = (state_q == ST_FAIL);
    assign index       = index_q;
    assign timed_out   = timed_out_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_player_input_checker.sv
// -----------------------------------------------------------------------------
// tb_player_input_checker
// Directed rounds followed by randomized rounds. Each round is described as a
// list of key colours and inter-key gaps; the outcome (pass/fail, pulse edge,
// index at the pulse, timed_out) is predicted from the round rules directly.
// -----------------------------------------------------------------------------
module tb_player_input_checker;

    localparam int T = 16;
    localparam logic [14:0] SEQ_A = 15'b101_100_011_010_001;

    logic        clock;
    logic        Resetn;
    logic        start;
    logic [2:0]  level;
    logic [14:0] colour_seq;
    logic        key_valid;
    logic [2:0]  key_colour;
    logic        busy;
    logic [3:0]  index;
    logic [2:0]  expected_colour;
    logic        round_pass;
    logic        round_fail;
    logic        timed_out;
    logic [1:0]  debug_state;

    player_input_checker #(
        .NUM_COLOURS    (5),
        .COLOUR_W       (3),
        .TIMEOUT_CYCLES (T),
        .TIMER_W        (5)
    ) dut (
        .clock           (clock),
        .Resetn          (Resetn),
        .start           (start),
        .level           (level),
        .colour_seq      (colour_seq),
        .key_valid       (key_valid),
        .key_colour      (key_colour),
        .busy            (busy),
        .index           (index),
        .expected_colour (expected_colour),
        .round_pass      (round_pass),
        .round_fail      (round_fail),
        .timed_out       (timed_out),
        .debug_state     (debug_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    // current round description
    logic [2:0]  r_col[8];
    int          r_gap[8];
    int          r_n;
    logic [2:0]  r_lvl;
    logic [14:0] r_seq;
    bit          r_noisy;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_index"}, 32'(index), 32'd0);
        check({tag, "_exp"},   32'(expected_colour), 32'd0);
        check({tag, "_pass"},  32'(round_pass), 32'd0);
        check({tag, "_fail"},  32'(round_fail), 32'd0);
    endtask

    function automatic logic [2:0] seq_colour(input logic [14:0] s, input int pos);
        return 3'((s >> (3 * (pos - 1))) & 15'd7);
    endfunction

    // Round outcome from the rules: a key more than T+1 edges after the last
    // clear is too late (timeout fires at T+1); a wrong colour fails on its
    // edge; the level-th matching key passes on its edge.
    task automatic predict(output int kind, output int edge_at, output int idx, output logic to);
        int t;
        int pos;
        t = 0;
        pos = 1;
        exp_q.delete();
        for (int i = 0; i < r_n; i++) begin
            if (r_gap[i] > T + 1) begin
                kind = 2; edge_at = t + T + 1; idx = pos; to = 1'b1;
                return;
            end
            t += r_gap[i];
            if (r_col[i] != seq_colour(r_seq, pos)) begin
                kind = 2; edge_at = t; idx = pos; to = 1'b0;
                return;
            end
            if (pos == int'(r_lvl)) begin
                kind = 1; edge_at = t; idx = pos; to = 1'b0;
                return;
            end
            pos++;
            exp_q.push_back(4'(pos));
        end
        kind = 2; edge_at = t + T + 1; idx = pos; to = 1'b1;
    endtask

    task automatic run_round(input string name);
        int   kind, exp_edge, exp_idx;
        logic exp_to;
        int   key_at[8];
        int   acc, ki, seen_edge, seen_kind;
        logic [3:0] seen_idx;
        logic seen_to;
        bit   keyed;

        predict(kind, exp_edge, exp_idx, exp_to);
        acc = 0;
        for (int i = 0; i < r_n; i++) begin
            acc += r_gap[i];
            key_at[i] = acc;
        end

        start = 1'b1; level = r_lvl; colour_seq = r_seq;
        tick;
        start = 1'b0;
        check({name, "_start_busy"},  32'(busy), 32'd1);
        check({name, "_start_index"}, 32'(index), 32'd1);
        check({name, "_start_colour"}, 32'(expected_colour), 32'(seq_colour(r_seq, 1)));
        check({name, "_start_to"},    32'(timed_out), 32'd0);

        seen_edge = -1; seen_kind = 0; seen_idx = '0; seen_to = 1'b0; ki = 0;
        for (int k = 1; k <= 300 && seen_edge < 0; k++) begin
            keyed = 1'b0;
            if (ki < r_n && key_at[ki] == k) begin
                key_valid = 1'b1; key_colour = r_col[ki]; ki++; keyed = 1'b1;
            end else begin
                key_valid = 1'b0; key_colour = 3'($urandom);
            end
            if (r_noisy && k <= exp_edge) begin
                start = 1'b1; level = 3'($urandom); colour_seq = 15'($urandom);
            end
            tick;
            key_valid = 1'b0; start = 1'b0;
            if (round_pass || round_fail) begin
                seen_edge = k;
                seen_kind = {30'd0, round_fail, round_pass};
                seen_idx  = index;
                seen_to   = timed_out;
            end else if (keyed && exp_q.size() > 0) begin
                check({name, "_step_index"}, 32'(index), 32'(exp_q.pop_front()));
                check({name, "_step_busy"},  32'(busy), 32'd1);
            end
        end

        if (seen_edge < 0) begin
            check({name, "_pulse_seen"}, 32'd0, 32'd1);
        end else begin
            check({name, "_pulse_edge"},  32'(seen_edge), 32'(exp_edge));
            check({name, "_pulse_kind"},  32'(seen_kind), 32'(kind));
            check({name, "_pulse_index"}, 32'(seen_idx), 32'(exp_idx));
            check({name, "_pulse_to"},    32'(seen_to), 32'(exp_to));
        end
        tick;
        check_quiet({name, "_after"});
        check({name, "_after_to"}, 32'(timed_out), 32'(exp_to));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Resetn = 1'b0; start = 1'b0; level = '0; colour_seq = '0;
        key_valid = 1'b0; key_colour = '0; r_noisy = 1'b0;

        repeat (3) tick;
        check_quiet("reset");
        check("reset_to", 32'(timed_out), 32'd0);
        Resetn = 1'b1;
        tick;

        // 1: full five-colour pass, keys 3 cycles apart
        r_seq = SEQ_A; r_lvl = 3'd5; r_n = 5;
        for (int i = 0; i < 5; i++) begin
            r_col[i] = 3'(i + 1); r_gap[i] = 3;
        end
        run_round("t1");

        // 2: mismatch on second key of a level-3 round
        r_lvl = 3'd3; r_n = 2;
        r_col[0] = 3'b001; r_gap[0] = 2;
        r_col[1] = 3'b011; r_gap[1] = 2;
        run_round("t2");

        // 3: timeout after first key of a level-2 round
        r_lvl = 3'd2; r_n = 1;
        r_col[0] = 3'b001; r_gap[0] = 2;
        run_round("t3");
        repeat (4) tick;
        check("t3_to_held", 32'(timed_out), 32'd1);

        // 4: key exactly in the expiry cycle
        r_lvl = 3'd1; r_n = 1;
        r_col[0] = 3'b001; r_gap[0] = T + 1;
        run_round("t4");

        // 5: illegal levels and idle keys are ignored
        for (int l = 0; l < 3; l++) begin
            start = 1'b1; level = (l == 0) ? 3'd0 : ((l == 1) ? 3'd6 : 3'd7);
            colour_seq = SEQ_A;
            tick;
            start = 1'b0;
            check_quiet("t5_bad_level");
        end
        key_valid = 1'b1; key_colour = 3'b001;
        tick;
        key_valid = 1'b0;
        check_quiet("t5_idle_key");
        // repeated start throughout a round leaves it untouched
        r_lvl = 3'd3; r_n = 3; r_noisy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_col[i] = 3'(i + 1); r_gap[i] = 2;
        end
        run_round("t5_mid_start");
        r_noisy = 1'b0;

        // 6: asynchronous reset mid-round
        start = 1'b1; level = 3'd3; colour_seq = SEQ_A;
        tick;
        start = 1'b0; key_valid = 1'b1; key_colour = 3'b001;
        tick;
        key_valid = 1'b0;
        check("t6_pre_index", 32'(index), 32'd2);
        #3;
        Resetn = 1'b0;
        #1;
        check_quiet("t6_reset");
        check("t6_reset_to", 32'(timed_out), 32'd0);
        repeat (3) begin
            tick;
            check("t6_held_pass", 32'(round_pass), 32'd0);
            check("t6_held_fail", 32'(round_fail), 32'd0);
        end
        Resetn = 1'b1;
        tick;
        r_seq = SEQ_A; r_lvl = 3'd1; r_n = 1;
        r_col[0] = 3'b001; r_gap[0] = 1;
        run_round("t6_after");

        // randomized rounds
        for (int r = 0; r < 25; r++) begin
            r_lvl = 3'($urandom_range(1, 5));
            r_seq = 15'($urandom);
            r_n = int'(r_lvl);
            if ($urandom_range(0, 9) == 0) r_n = $urandom_range(0, int'(r_lvl) - 1);
            for (int i = 0; i < r_n; i++) begin
                r_col[i] = ($urandom_range(0, 14) == 0) ? 3'($urandom) : seq_colour(r_seq, i + 1);
                case ($urandom_range(0, 9))
                    0:       r_gap[i] = T + 1;
                    1:       r_gap[i] = T + 1 + $urandom_range(1, 3);
                    default: r_gap[i] = $urandom_range(1, 6);
                endcase
            end
            r_noisy = ($urandom_range(0, 1) == 1);
            run_round("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
